// File: rtl/sram_arbiter_if.sv
// Bundle of requester-side and SRAM-side signals shared by the two-port SRAM arbiter.
// The arbiter uses the slave modport; requesters and the SRAM model use the master side.
interface sram_arbiter_if;
    logic        req0;
    logic        req1;
    logic        we0;
    logic        we1;
    logic [31:0] addr0;
    logic [31:0] addr1;
    logic [31:0] wdata0;
    logic [31:0] wdata1;
    logic        ack0;
    logic        ack1;
    logic [31:0] rdata;
    logic        busy;
    logic        owner;
    logic        sram_cs;
    logic        sram_oe;
    logic        sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
        output ack0, ack1, rdata, busy, owner,
        output sram_cs, sram_oe, sram_we, sram_addr, sram_din
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, sram_dout,
        input  ack0, ack1, rdata, busy, owner,
        input  sram_cs, sram_oe, sram_we, sram_addr, sram_din
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin two-port arbiter that sequences one SRAM access at a time through
// SETUP -> ACCESS (WAIT_CYCLES long) -> DONE, returning read data and a one-cycle ack.
module sram_arbiter #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS,
        ST_DONE
    } state_e;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        wr_q;
    logic        owner_q;
    logic        busy_q;
    logic        cs_q;
    logic        oe_q;
    logic        we_q;
    logic        ack0_q;
    logic        ack1_q;
    logic [31:0] addr_q;
    logic [31:0] din_q;
    logic [31:0] rdata_q;

    logic        grant_valid_d;
    logic        grant_port_d;
    logic        grant_wr_d;
    logic [31:0] grant_addr_d;
    logic [31:0] grant_data_d;

    // On a tie the port that did not win last time goes next.
    always_comb begin
        grant_valid_d = bus.req0 | bus.req1;
        grant_port_d  = (bus.req0 && bus.req1) ? ~owner_q : bus.req1;
        grant_wr_d    = grant_port_d ? bus.we1    : bus.we0;
        grant_addr_d  = grant_port_d ? bus.addr1  : bus.addr0;
        grant_data_d  = grant_port_d ? bus.wdata1 : bus.wdata0;
    end

    // NOTE: every register here uses <= so all next-state reads see the pre-edge values;
    // mixing in blocking assignments would make the result depend on statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            owner_q <= 1'b0;
            busy_q  <= 1'b0;
            cs_q    <= 1'b0;
            oe_q    <= 1'b0;
            we_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_valid_d) begin
                        owner_q <= grant_port_d;
                        wr_q    <= grant_wr_d;
                        addr_q  <= grant_addr_d;
                        din_q   <= grant_data_d;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b1;
                        state_q <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    cnt_q   <= CNT_LOAD;
                    oe_q    <= ~wr_q;
                    we_q    <= wr_q;
                    state_q <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) rdata_q <= bus.sram_dout;
                        cs_q    <= 1'b0;
                        oe_q    <= 1'b0;
                        we_q    <= 1'b0;
                        ack0_q  <= ~owner_q;
                        ack1_q  <= owner_q;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_DONE: begin
                    ack0_q  <= 1'b0;
                    ack1_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
    assign bus.owner     = owner_q;
    assign bus.sram_cs   = cs_q;
    assign bus.sram_oe   = oe_q;
    assign bus.sram_we   = we_q;
    assign bus.sram_addr = addr_q;
    assign bus.sram_din  = din_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: a WAIT_CYCLES=2 instance with a small SRAM model,
// plus WAIT_CYCLES=1 and 15 instances for latency and strobe-width checks.
module tb_sram_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    logic [31:0] mem [0:255];

    sram_arbiter_if bus ();
    sram_arbiter_if bus1 ();
    sram_arbiter_if bus15 ();

    sram_arbiter #(.WAIT_CYCLES(2))  dut   (.clk(clk), .rst_n(rst_n), .bus(bus));
    sram_arbiter #(.WAIT_CYCLES(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    sram_arbiter #(.WAIT_CYCLES(15)) dut15 (.clk(clk), .rst_n(rst_n), .bus(bus15));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Asynchronous-read SRAM model with write on the rising edge.
    assign bus.sram_dout   = mem[bus.sram_addr[7:0]];
    assign bus1.sram_dout  = 32'hCAFE_0001;
    assign bus15.sram_dout = 32'hCAFE_000F;

    always @(posedge clk) begin
        if (bus.sram_cs && bus.sram_we) mem[bus.sram_addr[7:0]] <= bus.sram_din;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Issues one request on the given port, drops it after the grant edge and
    // optionally changes the requester's address at cycle 2. Cycle index of the ack
    // is returned in lat (-1 if none within the budget).
    task automatic do_txn(input bit port, input bit wr, input logic [31:0] a,
                          input logic [31:0] d, input logic [31:0] a_late,
                          output int lat, output int oe_n, output int we_n,
                          output bit other_ack, output bit overlap,
                          output bit addr_bad, output bit din_bad,
                          output logic [31:0] rd_at_ack);
        lat = -1; oe_n = 0; we_n = 0;
        other_ack = 0; overlap = 0; addr_bad = 0; din_bad = 0;
        rd_at_ack = 'x;
        if (port) begin
            bus.req1 = 1'b1; bus.we1 = wr; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = wr; bus.addr0 = a; bus.wdata0 = d;
        end
        for (int c = 1; c <= 30 && lat < 0; c++) begin
            tick();
            if (c == 1) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
            if (c == 2) begin
                if (port) bus.addr1 = a_late; else bus.addr0 = a_late;
            end
            if (bus.sram_oe) oe_n++;
            if (bus.sram_we) we_n++;
            if (bus.sram_oe && bus.sram_we) overlap = 1;
            if (bus.sram_cs && bus.sram_addr !== a) addr_bad = 1;
            if (bus.sram_we && bus.sram_din !== d) din_bad = 1;
            if ((port ? bus.ack0 : bus.ack1) === 1'b1) other_ack = 1;
            if ((port ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = c;
                rd_at_ack = bus.rdata;
            end
        end
        tick();
    endtask

    task automatic test_reset;
        apply_reset();
        #1;
        checks++;
        if ({bus.ack0, bus.ack1, bus.busy, bus.owner, bus.sram_cs, bus.sram_oe, bus.sram_we} !== 7'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000000",
                     {bus.ack0, bus.ack1, bus.busy, bus.owner, bus.sram_cs, bus.sram_oe, bus.sram_we});
        end
        checks++;
        if ({bus.rdata, bus.sram_addr, bus.sram_din} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: rdata=%h addr=%h din=%h expected all zero",
                     bus.rdata, bus.sram_addr, bus.sram_din);
        end
    endtask

    task automatic test_single_read;
        int lat, oe_n, we_n;
        bit oth, ovl, ab, db;
        logic [31:0] rd;
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h10, lat, oe_n, we_n, oth, ovl, ab, db, rd);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL read0_latency: got %0d expected 4", lat); end
        checks++;
        if (oe_n !== 2 || we_n !== 0) begin
            errors++; $display("FAIL read0_strobes: oe=%0d we=%0d expected oe=2 we=0", oe_n, we_n);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read0_rdata: got %h expected deadbeef", rd); end
        checks++;
        if (oth !== 1'b0) begin errors++; $display("FAIL read0_ack1: got %b expected 0", oth); end
    endtask

    task automatic test_write_read;
        int lat, oe_n, we_n;
        bit oth, ovl, ab, db;
        logic [31:0] rd;
        do_txn(1'b1, 1'b1, 32'h20, 32'h12345678, 32'h20, lat, oe_n, we_n, oth, ovl, ab, db, rd);
        checks++;
        if (we_n !== 2 || oe_n !== 0 || ovl !== 1'b0) begin
            errors++; $display("FAIL write1_strobes: we=%0d oe=%0d overlap=%b expected we=2 oe=0 overlap=0", we_n, oe_n, ovl);
        end
        checks++;
        if (db !== 1'b0 || lat !== 4) begin
            errors++; $display("FAIL write1_din_lat: din_bad=%b lat=%0d expected 0 and 4", db, lat);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL write1_rdata_kept: got %h expected deadbeef", rd); end
        do_txn(1'b1, 1'b0, 32'h20, 32'h0, 32'h20, lat, oe_n, we_n, oth, ovl, ab, db, rd);
        checks++;
        if (rd !== 32'h12345678 || lat !== 4) begin
            errors++; $display("FAIL read1_after_write: rdata=%h lat=%0d expected 12345678 and 4", rd, lat);
        end
    endtask

    task automatic test_hold_change;
        int lat, oe_n, we_n;
        bit oth, ovl, ab, db;
        logic [31:0] rd;
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h30, lat, oe_n, we_n, oth, ovl, ab, db, rd);
        checks++;
        if (ab !== 1'b0) begin errors++; $display("FAIL hold_addr: addr_changed=%b expected 0", ab); end
        checks++;
        if (rd !== 32'hDEADBEEF || lat !== 4) begin
            errors++; $display("FAIL hold_dropped_ack: rdata=%h lat=%0d expected deadbeef and 4", rd, lat);
        end
    endtask

    task automatic test_simultaneous;
        int  n_acks;
        bit  ack_port [0:7];
        int  ack_cyc  [0:7];
        logic [31:0] ack_rd [0:7];
        bit  exp_port [0:3];
        int  exp_cyc  [0:3];
        exp_port = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_cyc  = '{4, 9, 14, 19};
        n_acks = 0;
        apply_reset();
        bus.we0 = 1'b0; bus.addr0 = 32'h10;
        bus.we1 = 1'b0; bus.addr1 = 32'h20;
        bus.req0 = 1'b1; bus.req1 = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            tick();
            if (n_acks >= 4) begin bus.req0 = 1'b0; bus.req1 = 1'b0; end
            if ((bus.ack0 || bus.ack1) && n_acks < 8) begin
                ack_port[n_acks] = bus.ack1;
                ack_cyc[n_acks]  = c;
                ack_rd[n_acks]   = bus.rdata;
                n_acks++;
            end
        end
        checks++;
        if (n_acks !== 4) begin errors++; $display("FAIL rr_count: got %0d acks expected 4", n_acks); end
        for (int i = 0; i < 4; i++) begin
            if (i < n_acks) begin
                checks++;
                if (ack_port[i] !== exp_port[i] || ack_cyc[i] !== exp_cyc[i]) begin
                    errors++;
                    $display("FAIL rr_grant%0d: port=%0d cycle=%0d expected port=%0d cycle=%0d",
                             i, ack_port[i], ack_cyc[i], exp_port[i], exp_cyc[i]);
                end
                checks++;
                if (ack_rd[i] !== (exp_port[i] ? 32'h12345678 : 32'hDEADBEEF)) begin
                    errors++;
                    $display("FAIL rr_rdata%0d: got %h expected %h", i, ack_rd[i],
                             exp_port[i] ? 32'h12345678 : 32'hDEADBEEF);
                end
            end
        end
    endtask

    task automatic test_reset_mid_access;
        int lat, oe_n, we_n;
        bit oth, ovl, ab, db, late_ack;
        logic [31:0] rd;
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 32'h40; bus.wdata0 = 32'hAAAA5555;
        tick();
        bus.req0 = 1'b0;
        tick();
        tick();
        checks++;
        if ({bus.sram_cs, bus.sram_we, bus.busy} !== 3'b111) begin
            errors++; $display("FAIL mid_pre: cs/we/busy=%b expected 111", {bus.sram_cs, bus.sram_we, bus.busy});
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.sram_cs, bus.sram_we, bus.sram_oe, bus.busy, bus.ack0, bus.ack1} !== 6'b0) begin
            errors++;
            $display("FAIL mid_async_clear: cs/we/oe/busy/ack0/ack1=%b expected 000000",
                     {bus.sram_cs, bus.sram_we, bus.sram_oe, bus.busy, bus.ack0, bus.ack1});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        late_ack = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (bus.ack0 || bus.ack1 || bus.busy) late_ack = 1'b1;
        end
        checks++;
        if (late_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack: activity=%b expected 0", late_ack); end
        do_txn(1'b0, 1'b0, 32'h10, 32'h0, 32'h10, lat, oe_n, we_n, oth, ovl, ab, db, rd);
        checks++;
        if (lat !== 4 || rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL mid_recover: lat=%0d rdata=%h expected 4 and deadbeef", lat, rd);
        end
    endtask

    task automatic test_wait_cycles;
        int lat1, lat15, oe1, oe15;
        logic [31:0] rd1, rd15;
        lat1 = -1; lat15 = -1; oe1 = 0; oe15 = 0;
        bus1.req0 = 1'b1;
        bus15.req0 = 1'b1;
        for (int c = 1; c <= 25; c++) begin
            tick();
            if (c == 1) begin bus1.req0 = 1'b0; bus15.req0 = 1'b0; end
            if (bus1.sram_oe)  oe1++;
            if (bus15.sram_oe) oe15++;
            if (bus1.ack0 && lat1 < 0)   begin lat1 = c;  rd1 = bus1.rdata;  end
            if (bus15.ack0 && lat15 < 0) begin lat15 = c; rd15 = bus15.rdata; end
        end
        checks++;
        if (lat1 !== 3 || oe1 !== 1) begin
            errors++; $display("FAIL wait1: lat=%0d oe=%0d expected 3 and 1", lat1, oe1);
        end
        checks++;
        if (lat15 !== 17 || oe15 !== 15) begin
            errors++; $display("FAIL wait15: lat=%0d oe=%0d expected 17 and 15", lat15, oe15);
        end
        checks++;
        if (rd1 !== 32'hCAFE_0001 || rd15 !== 32'hCAFE_000F) begin
            errors++; $display("FAIL wait_rdata: got %h %h expected cafe0001 cafe000f", rd1, rd15);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h30] = 32'h0BADF00D;
        rst_n = 1'b1;
        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = 0; bus.addr1 = 0; bus.wdata0 = 0; bus.wdata1 = 0;
        bus1.req0 = 0; bus1.req1 = 0; bus1.we0 = 0; bus1.we1 = 0;
        bus1.addr0 = 32'h5; bus1.addr1 = 0; bus1.wdata0 = 0; bus1.wdata1 = 0;
        bus15.req0 = 0; bus15.req1 = 0; bus15.we0 = 0; bus15.we1 = 0;
        bus15.addr0 = 32'h5; bus15.addr1 = 0; bus15.wdata0 = 0; bus15.wdata1 = 0;

        test_reset();
        test_single_read();
        test_write_read();
        test_hold_change();
        test_simultaneous();
        test_reset_mid_access();
        test_wait_cycles();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
